// File: rtl/ber_pkg.sv
// Shared definitions for the PRBS checker and any matching generator.
// Holds the checker state encoding, the sequence-select encoding and the
// per-sequence length / second-tap constants. The LFSR shifts toward the MSB,
// so the newest bit sits in bit 0.
package ber_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } ber_state_t;

    typedef enum logic [1:0] {
        SEL_PRBS7  = 2'b00,
        SEL_PRBS15 = 2'b01,
        SEL_PRBS20 = 2'b10,
        SEL_PRBS23 = 2'b11
    } prbs_sel_t;

    localparam int LFSR_W = 23;

    // Sequence length N (register bit N-1 is the first feedback tap).
    function automatic logic [4:0] prbs_len(input logic [1:0] sel);
        case (sel)
            SEL_PRBS7:  return 5'd7;
            SEL_PRBS15: return 5'd15;
            SEL_PRBS20: return 5'd20;
            default:    return 5'd23;
        endcase
    endfunction

    // Register index of the second feedback tap.
    function automatic logic [4:0] prbs_tap2(input logic [1:0] sel);
        case (sel)
            SEL_PRBS7:  return 5'd5;
            SEL_PRBS15: return 5'd13;
            SEL_PRBS20: return 5'd16;
            default:    return 5'd17;
        endcase
    endfunction

    // Mask of the low N register bits that belong to the selected sequence.
    function automatic logic [LFSR_W-1:0] prbs_mask(input logic [1:0] sel);
        case (sel)
            SEL_PRBS7:  return 23'h00007F;
            SEL_PRBS15: return 23'h007FFF;
            SEL_PRBS20: return 23'h0FFFFF;
            default:    return 23'h7FFFFF;
        endcase
    endfunction

endpackage

// File: rtl/ber_prbs_lfsr.sv
// Local sequence register for the PRBS checker.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset (L = 0)
//   select        - sequence select (ber_pkg encoding)
//   load          - 1: shift the received bit in; 0: free-run on own feedback
//   din           - received serial bit
//   expected      - predicted next bit, L[N-1] ^ L[tap2]
//   seed_zero     - the register value after a load shift would be all zero
//                   in its low N bits (stuck-at-0 seed)
module ber_prbs_lfsr
    import ber_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] select,
    input  logic       load,
    input  logic       din,
    output logic       expected,
    output logic       seed_zero
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] loaded;
    logic [4:0]        msb_idx;
    logic [4:0]        tap_idx;

    always_comb begin
        msb_idx  = prbs_len(select) - 5'd1;
        tap_idx  = prbs_tap2(select);
        expected = lfsr_q[msb_idx] ^ lfsr_q[tap_idx];
    end

    assign loaded    = {lfsr_q[LFSR_W-2:0], din};
    assign seed_zero = (loaded & prbs_mask(select)) == '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= {lfsr_q[LFSR_W-2:0], load ? din : expected};
        end
    end

endmodule

// File: rtl/ber_prbscheck.sv
// PRBS7/15/20/23 bit-error-rate checker.
// Seeds a local LFSR from the received stream, verifies it against a run of
// matching bits, then counts errors while locked and drops lock when one
// monitoring window collects too many errors.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   select_chk    - sequence select (00 PRBS7, 01 PRBS15, 10 PRBS20, 11 PRBS23)
//   prbs_in       - received serial bit, one per clock
//   clear_counts  - synchronous clear of err_count, bit_count, sync_loss
//   locked        - high while in LOCKED (registered)
//   bit_err       - one-cycle pulse per errored bit while LOCKED (registered)
//   err_count     - saturating errored-bit count
//   bit_count     - saturating compared-bit count
//   sync_loss     - saturating count of error-driven losses of lock
//
// state  | meaning
// SEARCH | L loads prbs_in; seed counter counts N samples
// VERIFY | L free-runs; VERIFY_LEN consecutive matches needed
// LOCKED | L free-runs; errors counted, window monitor active
module ber_prbscheck
    import ber_pkg::*;
#(
    parameter int VERIFY_LEN  = 64,
    parameter int WIN_LEN     = 256,
    parameter int LOSS_THRESH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  select_chk,
    input  logic        prbs_in,
    input  logic        clear_counts,
    output logic        locked,
    output logic        bit_err,
    output logic [31:0] err_count,
    output logic [31:0] bit_count,
    output logic [7:0]  sync_loss
);

    localparam int VW = $clog2(VERIFY_LEN + 1);
    localparam int WW = $clog2(WIN_LEN + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);
    localparam logic [VW-1:0] VERIFY_LAST = VW'(VERIFY_LEN - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] LOSS_LAST   = EW'(LOSS_THRESH - 1);

    ber_state_t  state_q, state_d;
    logic [1:0]  select_q;
    logic [4:0]  seed_q, seed_d, seed_last;
    logic [VW-1:0] ver_q, ver_d;
    logic [WW-1:0] win_q, win_d;
    logic [EW-1:0] werr_q, werr_d;
    logic [31:0] err_d, bits_d;
    logic [7:0]  loss_d;
    logic        bit_err_d;
    logic        expected, seed_zero, mismatch, win_wrap;

    ber_prbs_lfsr u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .select    (select_chk),
        .load      (state_q == SEARCH),
        .din       (prbs_in),
        .expected  (expected),
        .seed_zero (seed_zero)
    );

    assign seed_last = prbs_len(select_chk) - 5'd1;
    assign mismatch  = prbs_in ^ expected;
    assign win_wrap  = (win_q == WIN_LAST);

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        ver_d     = ver_q;
        win_d     = win_q;
        werr_d    = werr_q;
        err_d     = err_count;
        bits_d    = bit_count;
        loss_d    = sync_loss;
        bit_err_d = 1'b0;

        if (select_chk != select_q) begin
            // Sequence changed: reseed from scratch, counters left alone.
            state_d = SEARCH;
            seed_d  = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (seed_q == seed_last) begin
                        seed_d = '0;
                        if (!seed_zero) begin
                            state_d = VERIFY;
                            ver_d   = '0;
                        end
                    end else begin
                        seed_d = seed_q + 5'd1;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        state_d = SEARCH;
                        seed_d  = '0;
                    end else if (ver_q == VERIFY_LAST) begin
                        state_d = LOCKED;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        ver_d = ver_q + 1'b1;
                    end
                end
                LOCKED: begin
                    bits_d = (bit_count == '1) ? bit_count : bit_count + 32'd1;
                    win_d  = win_wrap ? '0 : win_q + 1'b1;
                    if (win_wrap) begin
                        werr_d = '0;
                    end
                    if (mismatch) begin
                        bit_err_d = 1'b1;
                        err_d     = (err_count == '1) ? err_count : err_count + 32'd1;
                        // The error on the last bit of a window still counts
                        // toward that window before it is cleared.
                        if (werr_q == LOSS_LAST) begin
                            state_d = SEARCH;
                            seed_d  = '0;
                            loss_d  = (sync_loss == '1) ? sync_loss : sync_loss + 8'd1;
                        end else if (!win_wrap) begin
                            werr_d = werr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    seed_d  = '0;
                end
            endcase
        end

        if (clear_counts) begin
            err_d  = '0;
            bits_d = '0;
            loss_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SEARCH;
            select_q  <= select_chk;
            seed_q    <= '0;
            ver_q     <= '0;
            win_q     <= '0;
            werr_q    <= '0;
            locked    <= 1'b0;
            bit_err   <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
            sync_loss <= '0;
        end else begin
            state_q   <= state_d;
            select_q  <= select_chk;
            seed_q    <= seed_d;
            ver_q     <= ver_d;
            win_q     <= win_d;
            werr_q    <= werr_d;
            locked    <= (state_d == LOCKED);
            bit_err   <= bit_err_d;
            err_count <= err_d;
            bit_count <= bits_d;
            sync_loss <= loss_d;
        end
    end

endmodule

// File: tb/tb_ber_prbscheck.sv
// Self-checking bench for ber_prbscheck: a queue-based behavioural model of
// the checker is stepped alongside the DUT every cycle, plus directed
// scenarios with hand-derived lock times and counts.
module tb_ber_prbscheck;

    localparam int VERIFY_LEN  = 64;
    localparam int WIN_LEN     = 256;
    localparam int LOSS_THRESH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  select_chk;
    logic        prbs_in;
    logic        clear_counts;
    logic        locked;
    logic        bit_err;
    logic [31:0] err_count;
    logic [31:0] bit_count;
    logic [7:0]  sync_loss;

    int checks   = 0;
    int failures = 0;

    ber_prbscheck #(
        .VERIFY_LEN  (VERIFY_LEN),
        .WIN_LEN     (WIN_LEN),
        .LOSS_THRESH (LOSS_THRESH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .select_chk   (select_chk),
        .prbs_in      (prbs_in),
        .clear_counts (clear_counts),
        .locked       (locked),
        .bit_err      (bit_err),
        .err_count    (err_count),
        .bit_count    (bit_count),
        .sync_loss    (sync_loss)
    );

    always #5 clock = ~clock;

    // Sequence recurrence b[k] = b[k-len] ^ b[k-tap].
    function automatic int tb_len(input logic [1:0] s);
        case (s)
            2'b00:   return 7;
            2'b01:   return 15;
            2'b10:   return 20;
            default: return 23;
        endcase
    endfunction

    function automatic int tb_tap(input logic [1:0] s);
        case (s)
            2'b00:   return 6;
            2'b01:   return 14;
            2'b10:   return 17;
            default: return 18;
        endcase
    endfunction

    // ---------------- generator ----------------
    bit g_hist[$];

    task automatic gen_reset();
        g_hist.delete();
        for (int i = 0; i < 23; i++) g_hist.push_back(1'b1);
    endtask

    task automatic gen_bit(input logic [1:0] s, output bit b);
        int sz;
        sz = g_hist.size();
        b = g_hist[sz - tb_len(s)] ^ g_hist[sz - tb_tap(s)];
        g_hist.push_back(b);
        if (g_hist.size() > 96) while (g_hist.size() > 48) void'(g_hist.pop_front());
    endtask

    // ---------------- reference model ----------------
    // m_state: 0 searching, 1 verifying, 2 locked
    bit          m_hist[$];
    int          m_state, m_seed, m_ver, m_win, m_werr;
    logic [1:0]  m_sel_q;
    bit          m_locked, m_bit_err;
    logic [31:0] m_err, m_bits;
    logic [7:0]  m_loss;

    task automatic model_reset(input logic [1:0] s);
        m_hist.delete();
        for (int i = 0; i < 23; i++) m_hist.push_back(1'b0);
        m_state = 0; m_seed = 0; m_ver = 0; m_win = 0; m_werr = 0;
        m_sel_q = s; m_locked = 0; m_bit_err = 0;
        m_err = 0; m_bits = 0; m_loss = 0;
    endtask

    task automatic model_step(input logic [1:0] s, input bit din, input bit clr);
        int n, t, sz, nstate;
        bit pred, allz;
        n = tb_len(s);
        t = tb_tap(s);
        sz = m_hist.size();
        pred = m_hist[sz - n] ^ m_hist[sz - t];
        nstate = m_state;
        m_bit_err = 0;
        if (s != m_sel_q) begin
            nstate = 0; m_seed = 0;
            m_hist.push_back(din);
        end else if (m_state == 0) begin
            m_hist.push_back(din);
            m_seed++;
            if (m_seed == n) begin
                m_seed = 0;
                allz = 1;
                for (int i = 1; i <= n; i++) if (m_hist[m_hist.size() - i]) allz = 0;
                if (!allz) begin nstate = 1; m_ver = 0; end
            end
        end else if (m_state == 1) begin
            m_hist.push_back(pred);
            if (din != pred) begin
                nstate = 0; m_seed = 0;
            end else begin
                m_ver++;
                if (m_ver == VERIFY_LEN) begin nstate = 2; m_win = 0; m_werr = 0; end
            end
        end else begin
            m_hist.push_back(pred);
            if (m_bits != 32'hFFFF_FFFF) m_bits = m_bits + 1;
            m_win++;
            if (din != pred) begin
                m_bit_err = 1;
                if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
                m_werr++;
                if (m_werr == LOSS_THRESH) begin
                    nstate = 0; m_seed = 0;
                    if (m_loss != 8'hFF) m_loss = m_loss + 1;
                end
            end
            if (m_win == WIN_LEN) begin m_win = 0; m_werr = 0; end
        end
        if (m_hist.size() > 96) while (m_hist.size() > 48) void'(m_hist.pop_front());
        if (clr) begin m_err = 0; m_bits = 0; m_loss = 0; end
        m_sel_q = s;
        m_state = nstate;
        m_locked = (nstate == 2);
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic [1:0] s, input bit din, input bit clr);
        select_chk   = s;
        prbs_in      = din;
        clear_counts = clr;
        model_step(s, din, clr);
        @(posedge clock);
        #1;
        checks++;
        if ({locked, bit_err, err_count, bit_count, sync_loss} !==
            {m_locked, m_bit_err, m_err, m_bits, m_loss}) begin
            failures++;
            $display("FAIL cycle t=%0t: got lk=%b be=%b err=%0d bits=%0d loss=%0d expected lk=%b be=%b err=%0d bits=%0d loss=%0d",
                     $time, locked, bit_err, err_count, bit_count, sync_loss,
                     m_locked, m_bit_err, m_err, m_bits, m_loss);
        end
    endtask

    task automatic do_reset(input logic [1:0] s);
        reset = 1'b1; select_chk = s; prbs_in = 1'b0; clear_counts = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset(s);
        gen_reset();
        check("reset_outputs", {locked, bit_err, err_count, bit_count, sync_loss}, 0);
    endtask

    task automatic run_to_lock(input logic [1:0] s, input int bound, output int n);
        bit g;
        n = 0;
        while (!locked && n < bound) begin
            gen_bit(s, g);
            tick(s, g, 1'b0);
            n++;
        end
    endtask

    task automatic run_clean(input logic [1:0] s, input int cnt);
        bit g;
        for (int i = 0; i < cnt; i++) begin
            gen_bit(s, g);
            tick(s, g, 1'b0);
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        int         lock_at;
    } lock_vec_t;

    lock_vec_t lock_tbl[4];

    initial begin
        int n, pulses, last_pulse, bad_gaps, drop_at;
        logic [31:0] e0, b0;
        bit g;
        logic [1:0] rs;
        int burst;

        lock_tbl[0] = '{2'b00, 7  + 64};
        lock_tbl[1] = '{2'b01, 15 + 64};
        lock_tbl[2] = '{2'b10, 20 + 64};
        lock_tbl[3] = '{2'b11, 23 + 64};

        // Lock time per sequence, then clean running counts every bit.
        for (int v = 0; v < 4; v++) begin
            do_reset(lock_tbl[v].sel);
            run_to_lock(lock_tbl[v].sel, 200, n);
            check("lock_time", n, lock_tbl[v].lock_at);
            run_clean(lock_tbl[v].sel, 300);
            check("clean_err_count", err_count, 0);
            check("clean_bit_count", bit_count, 300);
        end

        // PRBS23 with one flipped bit every 101: periodic errors, no loss.
        do_reset(2'b11);
        run_to_lock(2'b11, 200, n);
        check("lock23", locked, 1);
        pulses = 0; last_pulse = 0; bad_gaps = 0;
        for (int k = 1; k <= 10100; k++) begin
            gen_bit(2'b11, g);
            tick(2'b11, (k % 101 == 0) ? ~g : g, 1'b0);
            if (bit_err) begin
                if (pulses > 0 && k - last_pulse != 101) bad_gaps++;
                pulses++;
                last_pulse = k;
            end
        end
        check("noise_err_count", err_count, 100);
        check("noise_pulses", pulses, 100);
        check("noise_gaps", bad_gaps, 0);
        check("noise_sync_loss", sync_loss, 0);
        check("noise_bit_count", bit_count, 10100);

        // PRBS15: 20 inverted bits -> lock drops at the 16th.
        do_reset(2'b01);
        run_to_lock(2'b01, 200, n);
        run_clean(2'b01, 50);
        e0 = err_count;
        drop_at = 0;
        for (int k = 1; k <= 20; k++) begin
            gen_bit(2'b01, g);
            tick(2'b01, ~g, 1'b0);
            if (!locked && drop_at == 0) drop_at = k;
        end
        check("burst_drop_at", drop_at, 16);
        check("burst_err_delta", err_count - e0, 16);
        check("burst_sync_loss", sync_loss, 1);
        run_to_lock(2'b01, 300, n);
        check("burst_relock", locked, 1);

        // Select change PRBS7 -> PRBS20 while locked.
        do_reset(2'b00);
        run_to_lock(2'b00, 200, n);
        run_clean(2'b00, 30);
        e0 = err_count; b0 = bit_count;
        gen_bit(2'b10, g);
        tick(2'b10, g, 1'b0);
        check("selchg_locked", locked, 0);
        check("selchg_bits", bit_count, b0);
        run_to_lock(2'b10, 200, n);
        check("selchg_relock_time", n, 20 + 64);
        check("selchg_err", err_count, e0);
        check("selchg_bits_after", bit_count, b0);

        // Stuck-at-0 input never locks.
        do_reset(2'b00);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            tick(2'b00, 1'b0, 1'b0);
            if (locked) n++;
        end
        check("stuck0_locked_cycles", n, 0);

        // Repeated losses saturate sync_loss.
        do_reset(2'b00);
        for (int r = 0; r < 260; r++) begin
            run_to_lock(2'b00, 400, n);
            if (!locked) begin
                check("sat_relock", locked, 1);
                break;
            end
            n = 0;
            while (locked && n < 40) begin
                gen_bit(2'b00, g);
                tick(2'b00, ~g, 1'b0);
                n++;
            end
        end
        check("sync_loss_sat", sync_loss, 255);

        // clear_counts with a simultaneous error.
        run_to_lock(2'b00, 400, n);
        run_clean(2'b00, 20);
        gen_bit(2'b00, g);
        tick(2'b00, ~g, 1'b1);
        check("clear_bit_err", bit_err, 1);
        check("clear_counts", {err_count, bit_count, sync_loss}, 0);
        check("clear_keeps_lock", locked, 1);

        // Reset while locked.
        run_clean(2'b00, 10);
        check("pre_reset_locked", locked, 1);
        do_reset(2'b00);

        // Randomised traffic against the model.
        rs = 2'($urandom_range(0, 3));
        do_reset(rs);
        burst = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 499) == 0) rs = 2'($urandom_range(0, 3));
            if (burst == 0 && $urandom_range(0, 599) == 0) burst = 20;
            gen_bit(rs, g);
            if (burst > 0) begin
                g = ~g;
                burst--;
            end else if ($urandom_range(0, 79) == 0) begin
                g = ~g;
            end
            tick(rs, g, $urandom_range(0, 399) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
